// File: rtl/prv664_wb_outbuf_pkg.sv
// Shared writeback packet definition, reused by the writeback select unit.
package prv664_wb_outbuf_pkg;

  localparam int WB_XLEN  = 64;
  localparam int WB_VADDR = 64;
  localparam int WB_ITAGW = 8;
  localparam int WB_FFLAGW = 5;

  typedef struct packed {
    logic [WB_ITAGW-1:0]  itag;
    logic [WB_XLEN-1:0]   data;
    logic [WB_XLEN-1:0]   csrdata;
    logic [WB_VADDR-1:0]  branchaddr;
    logic                 jump;
    logic [WB_FFLAGW-1:0] fflag;
    logic                 mmio;
    logic                 load_acc_flt;
    logic                 load_addr_mis;
    logic                 load_page_flt;
    logic                 store_acc_flt;
    logic                 store_addr_mis;
    logic                 store_page_flt;
  } wb_pkt_t;

  localparam int WB_PKT_W = $bits(wb_pkt_t);

endpackage

// File: rtl/pip_wb_interface.sv
// Writeback handshake between one execution unit buffer and the writeback select unit.
interface pip_wb_interface;
  import prv664_wb_outbuf_pkg::*;

  logic                 valid;
  logic                 ready;
  logic [WB_ITAGW-1:0]  itag;
  logic [WB_XLEN-1:0]   data;
  logic [WB_XLEN-1:0]   csrdata;
  logic [WB_VADDR-1:0]  branchaddr;
  logic                 jump;
  logic [WB_FFLAGW-1:0] fflag;
  logic                 mmio;
  logic                 load_acc_flt;
  logic                 load_addr_mis;
  logic                 load_page_flt;
  logic                 store_acc_flt;
  logic                 store_addr_mis;
  logic                 store_page_flt;

  modport master (
    output valid, itag, data, csrdata, branchaddr, jump, fflag, mmio,
           load_acc_flt, load_addr_mis, load_page_flt,
           store_acc_flt, store_addr_mis, store_page_flt,
    input  ready
  );

  modport slave (
    input  valid, itag, data, csrdata, branchaddr, jump, fflag, mmio,
           load_acc_flt, load_addr_mis, load_page_flt,
           store_acc_flt, store_addr_mis, store_page_flt,
    output ready
  );

endinterface

// File: rtl/prv664_wb_fifo_core.sv
// Generic circular FIFO with wrap-bit pointers, registered ready/count and flush-to-empty.
module prv664_wb_fifo_core #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             inReady_o,
  input  logic             popReady_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [AW:0]      count_q, count_d;
  logic             inReady_q, inReady_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             empty, full, pushEn, popEn;

  assign empty  = (wrPtr_q == rdPtr_q);
  assign full   = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
  assign pushEn = push_i && inReady_q && !flush_i;
  assign valid_o = !empty && !flush_i;
  assign popEn  = valid_o && popReady_i;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (pushEn) wrPtr_d = wrPtr_q + PTR_ONE;
      if (popEn)  rdPtr_d = rdPtr_q + PTR_ONE;
    end
    count_d   = wrPtr_d - rdPtr_d;
    inReady_d = !((wrPtr_d[AW-1:0] == rdPtr_d[AW-1:0]) && (wrPtr_d[AW] != rdPtr_d[AW]));
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      inReady_q <= 1'b1;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      inReady_q <= inReady_d;
    end
  end

  // Payload storage is deliberately left unreset; it is only observed while valid.
  always_ff @(posedge clk_i) begin
    if (pushEn) mem_q[wrPtr_q[AW-1:0]] <= data_i;
  end

  assign data_o    = mem_q[rdPtr_q[AW-1:0]];
  assign inReady_o = inReady_q;
  assign count_o   = count_q;

  noPushWhenFull: assert property (@(posedge clk_i) disable iff (arst_i) !(pushEn && full));
  stableWhileStalled: assert property (@(posedge clk_i) disable iff (arst_i)
    (valid_o && !popReady_i) |=> $stable(data_o));
  countInRange: assert property (@(posedge clk_i) disable iff (arst_i) count_q <= (AW+1)'(DEPTH));

endmodule

// File: rtl/prv664_wb_outbuf.sv
// Writeback output buffer: queues unit results in order and presents them on a pip_wb master port.
module prv664_wb_outbuf
  import prv664_wb_outbuf_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = WB_XLEN,
  parameter int VADDR = WB_VADDR,
  parameter int ITAGW = WB_ITAGW
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   flush_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  wb_pkt_t                in_pkt_i,
  pip_wb_interface.master        wb_mif,
  output logic [$clog2(DEPTH):0] count_o
);

  // Packet field widths are fixed by the shared package; reject a mismatching override.
  if (XLEN != WB_XLEN || VADDR != WB_VADDR || ITAGW != WB_ITAGW) begin : gBadWidth
    $error("prv664_wb_outbuf: width parameters must match prv664_wb_outbuf_pkg");
  end

  wb_pkt_t headPkt;
  logic    headValid;

  prv664_wb_fifo_core #(
    .DEPTH (DEPTH),
    .WIDTH (WB_PKT_W)
  ) uCore (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .flush_i    (flush_i),
    .push_i     (in_valid_i),
    .data_i     (in_pkt_i),
    .inReady_o  (in_ready_o),
    .popReady_i (wb_mif.ready),
    .valid_o    (headValid),
    .data_o     (headPkt),
    .count_o    (count_o)
  );

  assign wb_mif.valid          = headValid;
  assign wb_mif.itag           = headPkt.itag;
  assign wb_mif.data           = headPkt.data;
  assign wb_mif.csrdata        = headPkt.csrdata;
  assign wb_mif.branchaddr     = headPkt.branchaddr;
  assign wb_mif.jump           = headPkt.jump;
  assign wb_mif.fflag          = headPkt.fflag;
  assign wb_mif.mmio           = headPkt.mmio;
  assign wb_mif.load_acc_flt   = headPkt.load_acc_flt;
  assign wb_mif.load_addr_mis  = headPkt.load_addr_mis;
  assign wb_mif.load_page_flt  = headPkt.load_page_flt;
  assign wb_mif.store_acc_flt  = headPkt.store_acc_flt;
  assign wb_mif.store_addr_mis = headPkt.store_addr_mis;
  assign wb_mif.store_page_flt = headPkt.store_page_flt;

endmodule

// File: tb/tb_prv664_wb_outbuf.sv
// Bench for prv664_wb_outbuf: queue-based reference plus directed literal checks.
module tb_prv664_wb_outbuf;
  import prv664_wb_outbuf_pkg::*;

  localparam int DEPTH = 2;

  logic    clk = 1'b0;
  logic    arst = 1'b1;
  logic    flush = 1'b0;
  logic    inValid = 1'b0;
  logic    inReady;
  wb_pkt_t inPkt = '0;
  logic [$clog2(DEPTH):0] count;
  wb_pkt_t obsPkt;

  int checks = 0;
  int failures = 0;
  wb_pkt_t modelQ[$];

  pip_wb_interface wbIf ();

  prv664_wb_outbuf #(.DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .arst_i     (arst),
    .flush_i    (flush),
    .in_valid_i (inValid),
    .in_ready_o (inReady),
    .in_pkt_i   (inPkt),
    .wb_mif     (wbIf.master),
    .count_o    (count)
  );

  always #5 clk = ~clk;

  always_comb begin
    obsPkt = '{itag: wbIf.itag, data: wbIf.data, csrdata: wbIf.csrdata,
               branchaddr: wbIf.branchaddr, jump: wbIf.jump, fflag: wbIf.fflag,
               mmio: wbIf.mmio, load_acc_flt: wbIf.load_acc_flt,
               load_addr_mis: wbIf.load_addr_mis, load_page_flt: wbIf.load_page_flt,
               store_acc_flt: wbIf.store_acc_flt, store_addr_mis: wbIf.store_addr_mis,
               store_page_flt: wbIf.store_page_flt};
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic wb_pkt_t mkPkt(input logic [7:0] itag, input logic [63:0] data);
    wb_pkt_t p;
    p = '0;
    p.itag = itag;
    p.data = data;
    return p;
  endfunction

  task automatic applyStimulus(input logic v, input wb_pkt_t p, input logic r, input logic f);
    @(posedge clk);
    #1;
    inValid   = v;
    inPkt     = p;
    wbIf.ready = r;
    flush     = f;
    #1;
  endtask

  // Reference: a plain FIFO of packets; the head is what must be on the bus.
  always @(negedge clk) begin
    bit acceptIn;
    if (arst) begin
      modelQ.delete();
    end else begin
      checkOutput("model_valid", 256'(wbIf.valid), 256'(modelQ.size() != 0 && !flush));
      checkOutput("model_count", 256'(count), 256'(modelQ.size()));
      checkOutput("model_in_ready", 256'(inReady), 256'(modelQ.size() < DEPTH));
      if (modelQ.size() != 0 && !flush)
        checkOutput("model_payload", 256'(obsPkt), 256'(modelQ[0]));
      if (flush) begin
        modelQ.delete();
      end else begin
        acceptIn = inValid && (modelQ.size() < DEPTH);
        if (modelQ.size() != 0 && wbIf.ready) void'(modelQ.pop_front());
        if (acceptIn) modelQ.push_back(inPkt);
      end
    end
  end

  initial begin
    wb_pkt_t idle;
    wb_pkt_t fpkt;
    idle = '0;
    wbIf.ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", 256'(wbIf.valid), 256'(0));
    checkOutput("reset_in_ready", 256'(inReady), 256'(1));
    checkOutput("reset_count", 256'(count), 256'(0));
    #2 arst = 1'b0;
    applyStimulus(1'b0, idle, 1'b1, 1'b0);

    // Single pass
    applyStimulus(1'b1, mkPkt(8'h05, 64'hDEAD_BEEF), 1'b1, 1'b0);
    checkOutput("single_pre_valid", 256'(wbIf.valid), 256'(0));
    applyStimulus(1'b0, idle, 1'b1, 1'b0);
    checkOutput("single_valid", 256'(wbIf.valid), 256'(1));
    checkOutput("single_itag", 256'(wbIf.itag), 256'(8'h05));
    checkOutput("single_data", 256'(wbIf.data), 256'(64'hDEAD_BEEF));
    applyStimulus(1'b0, idle, 1'b1, 1'b0);
    checkOutput("single_count_after", 256'(count), 256'(0));

    // Backpressure and full
    applyStimulus(1'b1, mkPkt(8'h01, 64'h11), 1'b0, 1'b0);
    applyStimulus(1'b1, mkPkt(8'h82, 64'h22), 1'b0, 1'b0);
    checkOutput("bp_count1", 256'(count), 256'(1));
    applyStimulus(1'b1, mkPkt(8'h03, 64'h33), 1'b0, 1'b0);
    checkOutput("bp_count_full", 256'(count), 256'(2));
    checkOutput("bp_in_ready", 256'(inReady), 256'(0));
    checkOutput("bp_head_itag", 256'(wbIf.itag), 256'(8'h01));
    applyStimulus(1'b1, mkPkt(8'h03, 64'h33), 1'b0, 1'b0);
    checkOutput("bp_count_held", 256'(count), 256'(2));
    checkOutput("bp_head_stable", 256'(wbIf.itag), 256'(8'h01));
    applyStimulus(1'b0, idle, 1'b1, 1'b0);
    checkOutput("bp_out0", 256'(wbIf.itag), 256'(8'h01));
    applyStimulus(1'b0, idle, 1'b1, 1'b0);
    checkOutput("bp_out1", 256'(wbIf.itag), 256'(8'h82));
    checkOutput("bp_out1_count", 256'(count), 256'(1));
    applyStimulus(1'b0, idle, 1'b0, 1'b0);
    checkOutput("bp_drained", 256'(count), 256'(0));

    // Streaming: one result per cycle across several pointer wraps
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, mkPkt(8'(i), 64'(i * 3)), 1'b1, 1'b0);
      if (i > 0) begin
        checkOutput("stream_itag", 256'(wbIf.itag), 256'(i - 1));
        checkOutput("stream_count", 256'(count), 256'(1));
      end
    end
    applyStimulus(1'b0, idle, 1'b1, 1'b0);
    checkOutput("stream_last", 256'(wbIf.itag), 256'(9));
    applyStimulus(1'b0, idle, 1'b1, 1'b0);
    checkOutput("stream_empty", 256'(count), 256'(0));

    // Flush while full, with an incoming result
    applyStimulus(1'b1, mkPkt(8'hA0, 64'h1), 1'b0, 1'b0);
    applyStimulus(1'b1, mkPkt(8'hA1, 64'h2), 1'b0, 1'b0);
    applyStimulus(1'b1, mkPkt(8'hA2, 64'h3), 1'b0, 1'b1);
    checkOutput("flush_valid_low", 256'(wbIf.valid), 256'(0));
    checkOutput("flush_count_before", 256'(count), 256'(2));
    applyStimulus(1'b0, idle, 1'b0, 1'b0);
    checkOutput("flush_count_after", 256'(count), 256'(0));
    checkOutput("flush_in_ready", 256'(inReady), 256'(1));
    // Flush with room available: the incoming result must still be dropped
    applyStimulus(1'b1, mkPkt(8'hB0, 64'h4), 1'b0, 1'b0);
    applyStimulus(1'b1, mkPkt(8'hB1, 64'h5), 1'b0, 1'b1);
    checkOutput("flush2_valid_low", 256'(wbIf.valid), 256'(0));
    applyStimulus(1'b0, idle, 1'b0, 1'b0);
    checkOutput("flush2_count", 256'(count), 256'(0));
    checkOutput("flush2_valid", 256'(wbIf.valid), 256'(0));

    // Field passthrough
    fpkt = mkPkt(8'h77, 64'h0123_4567_89AB_CDEF);
    fpkt.jump = 1'b1;
    fpkt.branchaddr = 64'h8000_0040;
    fpkt.fflag = 5'h11;
    fpkt.load_page_flt = 1'b1;
    applyStimulus(1'b1, fpkt, 1'b1, 1'b0);
    applyStimulus(1'b0, idle, 1'b1, 1'b0);
    checkOutput("pass_jump", 256'(wbIf.jump), 256'(1));
    checkOutput("pass_branchaddr", 256'(wbIf.branchaddr), 256'(64'h8000_0040));
    checkOutput("pass_fflag", 256'(wbIf.fflag), 256'(5'h11));
    checkOutput("pass_load_page_flt", 256'(wbIf.load_page_flt), 256'(1));
    checkOutput("pass_store_page_flt", 256'(wbIf.store_page_flt), 256'(0));
    applyStimulus(1'b0, idle, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a stalled, full buffer
    applyStimulus(1'b1, mkPkt(8'hC0, 64'h6), 1'b0, 1'b0);
    applyStimulus(1'b1, mkPkt(8'hC1, 64'h7), 1'b0, 1'b0);
    applyStimulus(1'b0, idle, 1'b0, 1'b0);
    checkOutput("pre_arst_count", 256'(count), 256'(2));
    #1 arst = 1'b1;
    #1;
    checkOutput("arst_valid", 256'(wbIf.valid), 256'(0));
    checkOutput("arst_in_ready", 256'(inReady), 256'(1));
    checkOutput("arst_count", 256'(count), 256'(0));
    @(posedge clk);
    #3 arst = 1'b0;
    applyStimulus(1'b0, idle, 1'b0, 1'b0);
    applyStimulus(1'b0, idle, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
